// File: rtl/sqr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sqr_sequencer_if
// Description : Host/datapath-facing signal bundle of the square-root
//               sequencer.
//               slave  modport : the sequencer itself
//               master modport : the host / datapath side
// Signals     : start    host -> seq   request a new operation
//               cont     dp   -> seq   loop-continue flag
//               stall    rf   -> seq   hold current state
//               Q        seq  -> dec   4-bit state word
//               busy     seq  -> host  Q != IDLE
//               done     seq  -> host  Q == DONE
//               err      seq  -> host  watchdog abort flag
//               iter_cnt seq  -> host  completed loop iterations
// Revision    : 1.0  initial release
// ============================================================================
interface sqr_sequencer_if #(
    parameter int ITER_W = 4
);
    logic              start;
    logic              cont;
    logic              stall;
    logic [3:0]        Q;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_cnt;

    modport slave (
        input  start, cont, stall,
        output Q, busy, done, err, iter_cnt
    );

    modport master (
        output start, cont, stall,
        input  Q, busy, done, err, iter_cnt
    );
endinterface : sqr_sequencer_if
`default_nettype wire

// File: rtl/sqr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sqr_sequencer
// Description : Registered state sequencer for the structural square-root
//               datapath. Walks a fixed microprogram
//               IDLE -> LOAD -> S2 -> S3 -> TEST -> (DONE | B6..B9 -> S2)
//               with one data-dependent loop steered by bus.cont, honours
//               register-file stalls and recovers from illegal state codes.
// Ports       : clk      system clock, rising edge
//               rst_n    asynchronous active-low reset
//               bus      sqr_sequencer_if.slave (start/cont/stall in,
//                        Q/busy/done/err/iter_cnt out)
// Parameters  : ITER_W   width of the iteration counter
//               MAX_ITER watchdog iteration limit (<= 2**ITER_W-1)
// Macro       : SQR_SEQ_WATCHDOG_EN - when defined, a TEST visit that wants
//               another iteration with iter_cnt == MAX_ITER exits to DONE and
//               raises err. When undefined the loop is unbounded, err is 0
//               and iter_cnt wraps.
// Revision    : 1.0  initial release
// ============================================================================
module sqr_sequencer #(
    parameter int ITER_W   = 4,
    parameter int MAX_ITER = 15
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sqr_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LOAD = 4'd1,
        S2   = 4'd2,
        S3   = 4'd3,
        TEST = 4'd4,
        DONE = 4'd5,
        B6   = 4'd6,
        B7   = 4'd7,
        B8   = 4'd8,
        B9   = 4'd9
    } state_t;

    // Elaboration-time sanity check of the watchdog limit.
    if (MAX_ITER > (2 ** ITER_W) - 1) begin : g_max_iter_check
        $error("sqr_sequencer: MAX_ITER exceeds the iter_cnt range");
    end

    // The state register is kept as a plain 4-bit word so that the six
    // unused codes 10..15 are representable and can be recovered from.
    logic [3:0]        state_q, state_d;
    logic [ITER_W-1:0] iter_q,  iter_d;
    logic              legal_state;

`ifdef SQR_SEQ_WATCHDOG_EN
    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    logic err_q, err_d;
`endif

    assign legal_state = (state_q <= B9);

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
`ifdef SQR_SEQ_WATCHDOG_EN
        err_d   = err_q;
`endif
        if (!legal_state) begin
            // Illegal code: back to IDLE even under stall, counters kept.
            state_d = IDLE;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = LOAD;
                        iter_d  = '0;
`ifdef SQR_SEQ_WATCHDOG_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                LOAD: state_d = S2;
                S2:   state_d = S3;
                S3:   state_d = TEST;
                TEST: begin
                    if (!bus.cont) begin
                        state_d = DONE;
`ifdef SQR_SEQ_WATCHDOG_EN
                    end else if (iter_q == MAX_ITER_C) begin
                        // Iteration budget spent: abort instead of looping.
                        state_d = DONE;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = B6;
                    end
                end
                B6:   state_d = B7;
                B7:   state_d = B8;
                B8:   state_d = B9;
                B9: begin
                    state_d = S2;
                    iter_d  = iter_q + 1'b1;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

`ifdef SQR_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: pure decodes of the registered state word
    // ------------------------------------------------------------------
    assign bus.Q        = state_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.iter_cnt = iter_q;

endmodule : sqr_sequencer
`default_nettype wire
